rxfifo_rd_sched: RTL and testbench

// Round-robin read scheduler that drains N_CH RX FIFO instances (LENGTH-deep, WIDTH-bit) onto one valid/ready stream.
// The FIFOs do not protect against over-reads, and their read data and fill count lag the read strobe by several cycles.

---
 rtl/rxfifo_rd_sched.sv | 207 ++++++++++++++++++++
 tb/tb_rxfifo_rd_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rxfifo_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rxfifo_rd_sched
//  Description : Round-robin read scheduler that drains N_CH RX FIFOs onto a
//                single valid/ready stream, tagging each word with its
//                channel number. The FIFOs have no over-read protection, and
//                their data/fill-count outputs lag the read strobe. This block
//                owns every read strobe and tracks that lag per channel, so
//                no FIFO is ever read past its contents.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    rst_n        in   asynchronous active-low reset
//    enable_i     in   1 = schedule reads, 0 = finish in-flight work and idle
//    fifo_data_i  in   FIFO head words, channel c at [c*WIDTH +: WIDTH]
//    fifo_locs_i  in   FIFO fill counts, channel c at [c*ADDR_BITS +: ADDR_BITS]
//    fifo_read_o  out  registered one-cycle read strobes, one bit per FIFO
//    m_data_o     out  {channel tag, data word}
//    m_valid_o    out  output word valid
//    m_ready_i    in   downstream accepts the word when valid && ready
//    busy_o       out  scheduler not idle
// ============================================================================
module rxfifo_rd_sched #(
    parameter int N_CH      = 2,
    parameter int WIDTH     = 24,
    parameter int ADDR_BITS = 14,
    parameter int RD_LAT    = 3,
    parameter int LOCS_LAT  = 4,
    localparam int CH_BITS  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [N_CH*WIDTH-1:0]     fifo_data_i,
    input  logic [N_CH*ADDR_BITS-1:0] fifo_locs_i,
    output logic [N_CH-1:0]           fifo_read_o,
    output logic [CH_BITS+WIDTH-1:0]  m_data_o,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic                      busy_o
);

    localparam int SETTLE_BITS = ($clog2(RD_LAT + 1) > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int INFL_BITS   = ($clog2(LOCS_LAT + 1) > 0) ? $clog2(LOCS_LAT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CH_BITS-1:0]         rr_q, rr_d;
    logic [N_CH-1:0]            read_q, read_d;
    logic [CH_BITS+WIDTH-1:0]   data_q, data_d;
    logic                       valid_q, valid_d;

    logic [N_CH-1:0]            eligible;
    logic [N_CH-1:0]            quiet;
    logic                       all_quiet;
    logic                       slot_free;
    logic                       grant_any;
    logic [CH_BITS-1:0]         grant_ch;
    logic [WIDTH-1:0]           grant_data;
    int                         best_off;
    int                         off;

    // The output register can take a new word if it is empty or being drained.
    assign slot_free = !valid_q || m_ready_i;
    assign all_quiet = &quiet;

    // ------------------------------------------------------------------------
    // Per-channel lag tracking
    //   settle   : blocks re-reading until the FIFO data output has advanced
    //   infl_sh  : strobes not yet reflected in the fill count; their number
    //              is subtracted from the (stale) count before deciding
    // ------------------------------------------------------------------------
    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            logic [SETTLE_BITS-1:0] settle_q, settle_d;
            logic [LOCS_LAT-1:0]    infl_sh_q, infl_sh_d;
            logic [INFL_BITS-1:0]   infl_cnt;
            logic [ADDR_BITS-1:0]   locs;

            assign locs = fifo_locs_i[c*ADDR_BITS +: ADDR_BITS];

            always_comb begin
                infl_cnt = '0;
                for (int k = 0; k < LOCS_LAT; k++) begin
                    infl_cnt = infl_cnt + INFL_BITS'(infl_sh_q[k]);
                end
            end

            assign eligible[c] = (state_q == ST_RUN) && (settle_q == '0) &&
                                 (locs > ADDR_BITS'(infl_cnt));
            assign quiet[c]    = (settle_q == '0) && (infl_sh_q == '0);

            always_comb begin
                settle_d = settle_q;
                if (read_d[c]) begin
                    settle_d = SETTLE_BITS'(RD_LAT);
                end else if (settle_q != '0) begin
                    settle_d = settle_q - SETTLE_BITS'(1);
                end
                infl_sh_d = (infl_sh_q << 1) | LOCS_LAT'(read_d[c]);
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    settle_q  <= '0;
                    infl_sh_q <= '0;
                end else begin
                    settle_q  <= settle_d;
                    infl_sh_q <= infl_sh_d;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Round-robin pick: smallest distance (mod N_CH) from the rr pointer
    // among eligible channels wins.
    // ------------------------------------------------------------------------
    always_comb begin
        best_off   = N_CH;
        off        = 0;
        grant_ch   = '0;
        grant_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            off = c - int'(rr_q);
            if (off < 0) begin
                off = off + N_CH;
            end
            if (eligible[c] && (off < best_off)) begin
                best_off   = off;
                grant_ch   = CH_BITS'(c);
                grant_data = fifo_data_i[c*WIDTH +: WIDTH];
            end
        end
        grant_any = slot_free && (best_off < N_CH);
    end

    // ------------------------------------------------------------------------
    // FSM next state and output register update
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        read_d  = '0;
        data_d  = data_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Stay until the last strobe has fully propagated through the
                // FIFO, so a later restart sees an accurate fill count.
                if (enable_i) begin
                    state_d = ST_RUN;
                end else if (!valid_q && all_quiet) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_any) begin
            for (int c = 0; c < N_CH; c++) begin
                read_d[c] = (grant_ch == CH_BITS'(c));
            end
            data_d  = {grant_ch, grant_data};
            valid_d = 1'b1;
            rr_d    = (grant_ch == CH_BITS'(N_CH - 1)) ? '0 : grant_ch + CH_BITS'(1);
        end else if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            read_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            read_q  <= read_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign fifo_read_o = read_q;
    assign m_data_o    = data_q;
    assign m_valid_o   = valid_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rxfifo_rd_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rxfifo_rd_sched
//  Description : Directed self-checking bench for rxfifo_rd_sched with two
//                lagged RX FIFO models (data lags 3 edges, count lags 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rxfifo_rd_sched;

    localparam int N_CH      = 2;
    localparam int WIDTH     = 24;
    localparam int ADDR_BITS = 14;
    localparam int CH_BITS   = 1;

    logic                      clk     = 1'b0;
    logic                      rst_n   = 1'b0;
    logic                      enable  = 1'b0;
    logic                      m_ready = 1'b1;
    logic [N_CH*WIDTH-1:0]     fifo_data;
    logic [N_CH*ADDR_BITS-1:0] fifo_locs;
    logic [N_CH-1:0]           fifo_read;
    logic [CH_BITS+WIDTH-1:0]  m_data;
    logic                      m_valid;
    logic                      busy;

    rxfifo_rd_sched #(
        .N_CH      (N_CH),
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS),
        .RD_LAT    (3),
        .LOCS_LAT  (4)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .fifo_data_i (fifo_data),
        .fifo_locs_i (fifo_locs),
        .fifo_read_o (fifo_read),
        .m_data_o    (m_data),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO models + monitor ----------------
    logic [WIDTH-1:0]   mem [N_CH][16];
    int                 wcnt [N_CH];
    int                 dptr [N_CH];
    int                 lcnt [N_CH];
    logic [3:0]         rd_sh [N_CH];
    int                 n_strobe [N_CH];
    int                 multi;
    int                 unstable;
    int                 cyc;
    logic               hold_v;
    logic [24:0]        hold_d;
    logic [24:0]        rx_q [$];
    int                 st_ch [$];
    int                 st_cyc [$];

    int n_total = 0;
    int n_bad   = 0;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            fifo_data[c*WIDTH +: WIDTH]         = mem[c][dptr[c] % 16];
            fifo_locs[c*ADDR_BITS +: ADDR_BITS] = 14'(wcnt[c] - lcnt[c]);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CH; c++) begin
                rd_sh[c]    <= '0;
                dptr[c]     <= 0;
                lcnt[c]     <= 0;
                n_strobe[c] <= 0;
            end
            multi    <= 0;
            unstable <= 0;
            cyc      <= 0;
            hold_v   <= 1'b0;
            hold_d   <= '0;
            rx_q.delete();
            st_ch.delete();
            st_cyc.delete();
        end else begin
            cyc <= cyc + 1;
            for (int c = 0; c < N_CH; c++) begin
                rd_sh[c] <= {rd_sh[c][2:0], fifo_read[c]};
                if (rd_sh[c][1]) dptr[c] <= dptr[c] + 1;   // data advances 3 edges after strobe edge
                if (rd_sh[c][2]) lcnt[c] <= lcnt[c] + 1;   // count drops 4 edges after strobe edge
                if (fifo_read[c]) begin
                    n_strobe[c] <= n_strobe[c] + 1;
                    st_ch.push_back(c);
                    st_cyc.push_back(cyc);
                end
            end
            if ($countones(fifo_read) > 1) multi <= multi + 1;
            if (m_valid && m_ready) rx_q.push_back(m_data);
            if (m_valid && !m_ready) begin
                if (hold_v && (m_data != hold_d)) unstable <= unstable + 1;
                hold_v <= 1'b1;
                hold_d <= m_data;
            end else begin
                hold_v <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int c, input int n, input logic [23:0] base);
        for (int i = 0; i < n; i++) mem[c][i] = base + 24'(i);
        wcnt[c] = n;
    endtask

    task automatic reset_env();
        @(negedge clk);
        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b1;
        wcnt[0] = 0;
        wcnt[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int t;
        logic [31:0] e;

        // ---- reset state, then enable with empty FIFOs ----
        wcnt[0] = 0;
        wcnt[1] = 0;
        repeat (2) @(negedge clk);
        chk_eq("rst_read",  32'(fifo_read), 0);
        chk_eq("rst_valid", 32'(m_valid), 0);
        chk_eq("rst_busy",  32'(busy), 0);
        chk_eq("rst_data",  32'(m_data), 0);
        enable = 1'b1;
        rst_n  = 1'b1;
        repeat (10) @(negedge clk);
        chk_eq("empty_busy",    32'(busy), 1);
        chk_eq("empty_strobes", 32'(n_strobe[0] + n_strobe[1]), 0);
        chk_eq("empty_valid",   32'(m_valid), 0);

        // ---- single channel, 5 words ----
        reset_env();
        load(0, 5, 24'hA00000);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        chk_eq("t2_nwords", 32'(rx_q.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) chk_eq("t2_word", 32'(rx_q[i]), 32'h00A00000 + 32'(i));
        end
        chk_eq("t2_strobes", 32'(n_strobe[0]), 5);
        for (int i = 1; i < 5; i++) begin
            if (i < st_cyc.size()) chk_eq("t2_gap", 32'(st_cyc[i] - st_cyc[i-1]), 4);
        end

        // ---- two channels, 3 words each: alternate ----
        reset_env();
        load(0, 3, 24'hB00000);
        load(1, 3, 24'hC00000);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        chk_eq("t3_strobes", 32'(st_ch.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < st_ch.size()) chk_eq("t3_order", 32'(st_ch[i]), 32'(i % 2));
        end
        if (st_cyc.size() > 1) chk_eq("t3_gap01", 32'(st_cyc[1] - st_cyc[0]), 1);
        chk_eq("t3_multi", 32'(multi), 0);
        for (int i = 0; i < 6; i++) begin
            e = ((i % 2) == 0) ? (32'h00B00000 + 32'(i / 2)) : (32'h01C00000 + 32'(i / 2));
            if (i < rx_q.size()) chk_eq("t3_word", 32'(rx_q[i]), e);
        end

        // ---- back-pressure on ch1 ----
        reset_env();
        load(1, 2, 24'hD00000);
        m_ready = 1'b0;
        enable  = 1'b1;
        repeat (12) @(negedge clk);
        chk_eq("t4_hold_strobes", 32'(n_strobe[1]), 1);
        chk_eq("t4_hold_valid",   32'(m_valid), 1);
        chk_eq("t4_hold_data",    32'(m_data), 32'h01D00000);
        chk_eq("t4_unstable",     32'(unstable), 0);
        m_ready = 1'b1;
        @(negedge clk);
        chk_eq("t4_next_valid", 32'(m_valid), 1);
        chk_eq("t4_next_data",  32'(m_data), 32'h01D00001);
        chk_eq("t4_next_read",  32'(fifo_read), 32'h2);
        repeat (10) @(negedge clk);
        chk_eq("t4_strobes", 32'(n_strobe[1]), 2);
        chk_eq("t4_nwords",  32'(rx_q.size()), 2);

        // ---- single word, stale count must not cause a second read ----
        reset_env();
        load(0, 1, 24'hE00000);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("t5_strobes", 32'(n_strobe[0]), 1);
        chk_eq("t5_nwords",  32'(rx_q.size()), 1);
        if (rx_q.size() > 0) chk_eq("t5_word", 32'(rx_q[0]), 32'h00E00000);

        // ---- enable drop right after a grant, then reset mid-burst ----
        reset_env();
        load(0, 5, 24'hF00000);
        enable = 1'b1;
        k = 0;
        while ((fifo_read == '0) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        chk_eq("t6_grant_seen", 32'(fifo_read), 1);
        enable = 1'b0;
        t = 0;
        while (busy && (t < 20)) begin
            @(negedge clk);
            t++;
        end
        chk_eq("t6_idle_lat", 32'(t), 5);
        chk_eq("t6_nwords",   32'(rx_q.size()), 1);
        chk_eq("t6_strobes",  32'(n_strobe[0]), 1);
        chk_eq("t6_valid",    32'(m_valid), 0);
        enable = 1'b1;
        k = 0;
        while (!m_valid && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        chk_eq("t6_refill", 32'(m_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("t6_arst_read",  32'(fifo_read), 0);
        chk_eq("t6_arst_valid", 32'(m_valid), 0);
        chk_eq("t6_arst_data",  32'(m_data), 0);
        chk_eq("t6_arst_busy",  32'(busy), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
